// File: rtl/data_pack_seq_pkg.sv
// Shared types and constants for the data_pack sequencer.
package data_pack_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ALIGN     = 3'd1,
        DATA      = 3'd2,
        PAD_SETUP = 3'd3,
        PAD       = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    localparam int unsigned ERR_W    = 3;
    localparam int unsigned ERR_ODD  = 0;
    localparam int unsigned ERR_SKEW = 1;
    localparam int unsigned ERR_CNT  = 2;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = 2;

endpackage

// File: rtl/data_pack_beat_cnt.sv
// Loadable saturating up/down counter with a zero flag.
module data_pack_beat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    assign zero_c = (cnt == '0);

    // Load wins; simultaneous inc/dec cancel; both directions saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !dec) begin
            if (cnt != '1) cnt <= cnt + W'(1);
        end else if (dec && !inc) begin
            if (!zero_c) cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/data_pack_seq.sv
// Tile sequencer in front of data_pack: gates AXI read beats, leads is_pad,
// injects zero-pad beats, counts packed outputs and reports sticky errors.
module data_pack_seq
    import data_pack_seq_pkg::*;
#(
    parameter int unsigned INPUT_AXI_CHNL = 8,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_vld,
    output logic                                 cmd_rdy,
    input  logic [CNT_WIDTH-1:0]                 cmd_data_beats,
    input  logic [CNT_WIDTH-1:0]                 cmd_pad_beats,
    input  logic [DATA_WIDTH*INPUT_AXI_CHNL-1:0] ddr_dat,
    input  logic [INPUT_AXI_CHNL-1:0]            ddr_vld,
    output logic                                 ddr_rdy,
    output logic [DATA_WIDTH*INPUT_AXI_CHNL-1:0] pack_dat,
    output logic [INPUT_AXI_CHNL-1:0]            pack_vld,
    output logic                                 is_pad,
    input  logic [INPUT_AXI_CHNL-1:0]            pack_dn_vld,
    output logic                                 done,
    output logic [ERR_W-1:0]                     err
);

    localparam int unsigned EXP_W = CNT_WIDTH + 1;

    state_t               state, state_nxt;
    logic                 accept, beat, skew, pad_dec, drain_last, out_inc;
    logic [CNT_WIDTH-1:0] data_cnt, pad_cnt, out_cnt;
    logic                 data_zero, pad_zero, out_zero_unused, dn_unused;
    logic [EXP_W-1:0]     exp_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;

    assign out_inc   = pack_dn_vld[0] && (state != IDLE);
    assign dn_unused = ^pack_dn_vld;

    data_pack_beat_cnt #(.W(CNT_WIDTH)) u_data_cnt (
        .clk(clk), .rst_n(rst_n), .load(accept),
        .load_val({cmd_data_beats[CNT_WIDTH-1:1], 1'b0}),
        .inc(1'b0), .dec(beat), .cnt(data_cnt), .zero_c(data_zero)
    );

    data_pack_beat_cnt #(.W(CNT_WIDTH)) u_pad_cnt (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val(cmd_pad_beats),
        .inc(1'b0), .dec(pad_dec), .cnt(pad_cnt), .zero_c(pad_zero)
    );

    data_pack_beat_cnt #(.W(CNT_WIDTH)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val('0),
        .inc(out_inc), .dec(1'b0), .cnt(out_cnt), .zero_c(out_zero_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        beat       = 1'b0;
        skew       = 1'b0;
        pad_dec    = 1'b0;
        drain_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    accept    = 1'b1;
                    state_nxt = ALIGN;
                end
            end
            ALIGN:     state_nxt = data_zero ? PAD_SETUP : DATA;
            DATA: begin
                if (ddr_rdy) begin
                    if (&ddr_vld) begin
                        beat = 1'b1;
                        if (data_cnt == CNT_WIDTH'(1)) state_nxt = PAD_SETUP;
                    end else if (|ddr_vld) begin
                        skew = 1'b1;
                    end else if (data_cnt[0]) begin
                        // Packer pairs by cycle: a hole mid-pair splits the pair.
                        skew = 1'b1;
                    end
                end
            end
            PAD_SETUP: state_nxt = pad_zero ? DRAIN : PAD;
            PAD: begin
                pad_dec = 1'b1;
                if (pad_cnt == CNT_WIDTH'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    drain_last = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs; is_pad comes from next state so it leads pack_vld by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rdy   <= 1'b0;
            ddr_rdy   <= 1'b0;
            is_pad    <= 1'b1;
            done      <= 1'b0;
            pack_vld  <= '0;
            pack_dat  <= '0;
            err       <= '0;
            exp_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            cmd_rdy   <= (state_nxt == IDLE);
            ddr_rdy   <= (state_nxt == DATA);
            is_pad    <= (state_nxt != DATA);
            done      <= drain_last;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            if (state_nxt == PAD) begin
                pack_vld <= '1;
                pack_dat <= '0;
            end else if ((state == DATA) && ddr_rdy) begin
                pack_vld <= ddr_vld;
                pack_dat <= ddr_dat;
            end else begin
                pack_vld <= '0;
                pack_dat <= '0;
            end
            if (accept) begin
                err          <= '0;
                err[ERR_ODD] <= cmd_data_beats[0];
                exp_cnt      <= EXP_W'(cmd_data_beats >> 1) + EXP_W'(cmd_pad_beats);
            end else begin
                if (skew) err[ERR_SKEW] <= 1'b1;
                if (drain_last && (EXP_W'(out_cnt) != exp_cnt)) err[ERR_CNT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_pack_seq.sv
// Scoreboard bench for data_pack_seq with a behavioural packer driving pack_dn_vld.
module tb_data_pack_seq;

    localparam int unsigned NCH = 8;
    localparam int unsigned DW  = 256;
    localparam int unsigned CW  = 16;
    localparam int unsigned BW  = NCH * DW;

    typedef struct {
        logic [NCH-1:0] vld;
        logic [BW-1:0]  dat;
        logic           pad;
    } beat_t;

    typedef struct {
        logic [2:0] err;
        int         rdy_cycles;
    } tile_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_vld, cmd_rdy;
    logic [CW-1:0] cmd_data_beats, cmd_pad_beats;
    logic [BW-1:0] ddr_dat, pack_dat;
    logic [NCH-1:0] ddr_vld, pack_vld, pack_dn_vld;
    logic          ddr_rdy, is_pad, done;
    logic [2:0]    err;

    int checks = 0;
    int errors = 0;
    beat_t exp_beats[$];
    tile_t exp_tiles[$];

    always #5 clk = ~clk;

    data_pack_seq #(.INPUT_AXI_CHNL(NCH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_data_beats(cmd_data_beats), .cmd_pad_beats(cmd_pad_beats),
        .ddr_dat(ddr_dat), .ddr_vld(ddr_vld), .ddr_rdy(ddr_rdy),
        .pack_dat(pack_dat), .pack_vld(pack_vld), .is_pad(is_pad),
        .pack_dn_vld(pack_dn_vld), .done(done), .err(err)
    );

    // Packer: re-registers is_pad; pad beats pass 1:1, data beats pair by cycle.
    logic pk_is_pad_q, pk_phase, pk_first, pk_dn;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_is_pad_q <= 1'b1;
            pk_phase    <= 1'b0;
            pk_first    <= 1'b0;
            pk_dn       <= 1'b0;
        end else begin
            pk_is_pad_q <= is_pad;
            if (pk_is_pad_q) begin
                pk_phase <= 1'b0;
                pk_dn    <= &pack_vld;
            end else if (!pk_phase) begin
                pk_phase <= 1'b1;
                pk_first <= &pack_vld;
                pk_dn    <= 1'b0;
            end else begin
                pk_phase <= 1'b0;
                pk_dn    <= pk_first && (&pack_vld);
            end
        end
    end
    assign pack_dn_vld = {NCH{pk_dn}};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic logic [BW-1:0] rnd_dat();
        logic [BW-1:0] d;
        for (int w = 0; w < BW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic monitor();
        beat_t e;
        tile_t t;
        logic  prev_pad = 1'b1;
        int    rdy_c = 0;
        int    low_c = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pad = 1'b1;
                rdy_c    = 0;
                low_c    = 0;
            end else begin
                if (pack_vld != '0) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", 64'(pack_vld), 64'(0));
                    end else begin
                        e = exp_beats.pop_front();
                        check("beat_vld", 64'(pack_vld), 64'(e.vld));
                        check("is_pad_lead", 64'(prev_pad), 64'(e.pad));
                        checks++;
                        if (pack_dat !== e.dat) begin
                            errors++;
                            $display("FAIL beat_dat: got %h required %h (low 64 bits)",
                                     pack_dat[63:0], e.dat[63:0]);
                        end
                    end
                end
                if (ddr_rdy) rdy_c++;
                if (!is_pad) low_c++;
                if (done) begin
                    if (exp_tiles.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        t = exp_tiles.pop_front();
                        check("done_err", 64'(err), 64'(t.err));
                        check("ddr_rdy_cycles", 64'(rdy_c), 64'(t.rdy_cycles));
                        check("is_pad_low_cycles", 64'(low_c), 64'(t.rdy_cycles));
                        check("beats_left_at_done", 64'(exp_beats.size()), 64'(0));
                    end
                    rdy_c = 0;
                    low_c = 0;
                end
                prev_pad = is_pad;
            end
        end
    endtask

    task automatic wait_cmd_rdy();
        int k = 0;
        while (!cmd_rdy && k < 50) begin @(negedge clk); k++; end
        check("wait_cmd_rdy", 64'(cmd_rdy), 64'(1));
    endtask

    // One tile: build a beat list, predict results from the packing rules, drive, wait done.
    task automatic run_tile(input int data, input int pad, input int gap_at, input int part_at,
                            input bit rnd);
        beat_t    items[$];
        beat_t    b;
        tile_t    t;
        int       n, fulls, pairs, k;
        bit       gap_used, part_used, e1;
        logic [2:0] e;
        n = data & ~1;
        fulls = 0; gap_used = 0; part_used = 0;
        while (fulls < n) begin
            b.dat = rnd_dat();
            b.pad = 1'b0;
            if (fulls == gap_at && !gap_used) begin
                b.vld = '0; gap_used = 1;
            end else if (fulls == part_at && !part_used) begin
                b.vld = NCH'($urandom_range(1, (1 << NCH) - 2)); part_used = 1;
            end else if (rnd && $urandom_range(0, 5) == 0) begin
                b.vld = '0;
            end else begin
                b.vld = '1; fulls++;
            end
            items.push_back(b);
        end
        e1 = 0; fulls = 0;
        foreach (items[i]) begin
            if (items[i].vld == '1) fulls++;
            else if (items[i].vld != '0) e1 = 1;
            else if (fulls % 2 == 1) e1 = 1;
        end
        pairs = 0;
        for (int i = 0; i + 1 < items.size(); i += 2)
            if (items[i].vld == '1 && items[i+1].vld == '1) pairs++;
        e = {(pairs + pad) != (n / 2 + pad), e1, 1'(data % 2)};
        foreach (items[i]) if (items[i].vld != '0) exp_beats.push_back(items[i]);
        for (int i = 0; i < pad; i++) begin
            b.vld = '1; b.dat = '0; b.pad = 1'b1;
            exp_beats.push_back(b);
        end
        t.err = e;
        t.rdy_cycles = items.size();
        exp_tiles.push_back(t);

        @(negedge clk);
        wait_cmd_rdy();
        cmd_vld = 1'b1;
        cmd_data_beats = CW'(data);
        cmd_pad_beats  = CW'(pad);
        @(negedge clk);
        cmd_vld = 1'b0;
        check("err_at_accept", 64'(err), 64'(data % 2));
        check("cmd_rdy_busy", 64'(cmd_rdy), 64'(0));
        if (items.size() > 0) begin
            k = 0;
            while (!ddr_rdy && k < 20) begin @(negedge clk); k++; end
            check("wait_ddr_rdy", 64'(ddr_rdy), 64'(1));
            foreach (items[i]) begin
                ddr_vld = items[i].vld;
                ddr_dat = items[i].dat;
                @(negedge clk);
            end
            ddr_vld = '0;
        end
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        check("wait_done", 64'(done), 64'(1));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("err_held", 64'(err), 64'(e));
        check("cmd_rdy_after_done", 64'(cmd_rdy), 64'(1));
    endtask

    initial begin
        beat_t b;
        int k;
        rst_n = 1'b0;
        cmd_vld = 1'b0; cmd_data_beats = '0; cmd_pad_beats = '0;
        ddr_vld = '0; ddr_dat = '0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'(0));
        check("rst_ddr_rdy", 64'(ddr_rdy), 64'(0));
        check("rst_pack_vld", 64'(pack_vld), 64'(0));
        check("rst_pack_dat_nonzero", 64'(pack_dat != '0), 64'(0));
        check("rst_is_pad", 64'(is_pad), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;

        run_tile(8, 0, -1, -1, 0);
        run_tile(4, 3, -1, -1, 0);
        run_tile(0, 2, -1, -1, 0);
        run_tile(6, 0, 3, -1, 0);
        run_tile(5, 0, -1, -1, 0);
        run_tile(4, 1, -1, 2, 0);

        // Reset in the middle of a long pad run.
        @(negedge clk);
        wait_cmd_rdy();
        for (int i = 0; i < 20; i++) begin
            b.vld = '1; b.dat = '0; b.pad = 1'b1;
            exp_beats.push_back(b);
        end
        cmd_vld = 1'b1; cmd_data_beats = '0; cmd_pad_beats = CW'(20);
        @(negedge clk);
        cmd_vld = 1'b0;
        k = 0;
        while (pack_vld == '0 && k < 20) begin @(negedge clk); k++; end
        check("wait_pad_beat", 64'(pack_vld), 64'({NCH{1'b1}}));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pack_vld", 64'(pack_vld), 64'(0));
        check("midrst_is_pad", 64'(is_pad), 64'(1));
        check("midrst_cmd_rdy", 64'(cmd_rdy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        exp_beats.delete();
        exp_tiles.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_cmd_rdy", 64'(cmd_rdy), 64'(1));
        run_tile(8, 2, -1, -1, 0);

        for (int i = 0; i < 8; i++)
            run_tile($urandom_range(0, 12), $urandom_range(0, 5), -1, -1, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
